// File: rtl/xilinx_led_pkg.sv
// Shared types for the status LED controller: per-channel LED modes and FSM states.
package xilinx_led_pkg;

  typedef enum logic [1:0] {
    LedOff   = 2'd0,
    LedOn    = 2'd1,
    LedBlink = 2'd2,
    LedPwm   = 2'd3
  } led_mode_e;

  typedef enum logic [1:0] {
    StLamp     = 2'd0,
    StRun      = 2'd1,
    StExitPass = 2'd2,
    StExitFail = 2'd3
  } led_state_e;

endpackage

// File: rtl/xilinx_led_pwm.sv
// One LED channel: selects off/on/blink/PWM drive from the shared prescaler.
module xilinx_led_pwm
  import xilinx_led_pkg::*;
#(
  parameter int unsigned PWM_WIDTH = 8
) (
  input  logic [1:0]           mode_i,
  input  logic [PWM_WIDTH-1:0] duty_i,
  input  logic [PWM_WIDTH-1:0] cnt_i,
  input  logic                 blink_i,
  output logic                 led_o
);

  always_comb begin
    led_o = 1'b0;
    case (led_mode_e'(mode_i))
      LedOff:   led_o = 1'b0;
      LedOn:    led_o = 1'b1;
      LedBlink: led_o = blink_i;
      LedPwm:   led_o = (cnt_i < duty_i);
      default:  led_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/xilinx_status_led_ctrl.sv
// Status LED controller: post-reset lamp test, per-channel run modes and sticky
// program-exit indication (solid on for pass, blinking exit code for fail).
module xilinx_status_led_ctrl
  import xilinx_led_pkg::*;
#(
  parameter int unsigned NUM_LEDS    = 4,
  parameter int unsigned CNT_WIDTH   = 27,
  parameter int unsigned PWM_WIDTH   = 8,
  parameter int unsigned LAMP_CYCLES = 1000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [2*NUM_LEDS-1:0]         mode_i,
  input  logic [PWM_WIDTH*NUM_LEDS-1:0] duty_i,
  input  logic                          exit_valid_i,
  input  logic [31:0]                   exit_value_i,
  output logic [NUM_LEDS-1:0]           led_o,
  output logic                          heartbeat_o
);

  localparam int unsigned LampW = (LAMP_CYCLES > 1) ? $clog2(LAMP_CYCLES) : 1;
  localparam logic [LampW-1:0] LampLast =
      LampW'((LAMP_CYCLES > 0) ? LAMP_CYCLES - 1 : 0);
  localparam led_state_e ResetState = (LAMP_CYCLES == 0) ? StRun : StLamp;

  led_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [LampW-1:0]    lamp_q, lamp_d;
  logic [31:0]         exit_q, exit_d;
  logic                pending_q, pending_d;
  logic                exit_prev_q;
  logic [NUM_LEDS-1:0] led_q, led_d;
  logic                hb_q;

  logic [NUM_LEDS-1:0] run_led;
  logic [NUM_LEDS-1:0] fail_pat;
  logic                accept;
  logic                pend_now;
  logic [31:0]         code_now;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    xilinx_led_pwm #(
      .PWM_WIDTH(PWM_WIDTH)
    ) u_ch (
      .mode_i (mode_i[2*i +: 2]),
      .duty_i (duty_i[PWM_WIDTH*i +: PWM_WIDTH]),
      .cnt_i  (cnt_q[PWM_WIDTH-1:0]),
      .blink_i(cnt_q[CNT_WIDTH-1]),
      .led_o  (run_led[i])
    );
  end

  // Exit edges are only taken before an exit state is reached.
  assign accept   = exit_valid_i & ~exit_prev_q & ((state_q == StLamp) | (state_q == StRun));
  assign pend_now = pending_q | accept;
  assign code_now = accept ? exit_value_i : exit_q;
  // A nonzero code with no visible low bits blinks every LED instead.
  assign fail_pat = (exit_q[NUM_LEDS-1:0] == '0) ? '1 : exit_q[NUM_LEDS-1:0];

  always_comb begin
    cnt_d     = cnt_q + CNT_WIDTH'(1);
    exit_d    = code_now;
    pending_d = pend_now;
    state_d   = state_q;
    lamp_d    = lamp_q;
    case (state_q)
      StLamp: begin
        if (lamp_q == LampLast) begin
          if (pend_now) begin
            state_d   = (code_now == 32'd0) ? StExitPass : StExitFail;
            pending_d = 1'b0;
          end else begin
            state_d = StRun;
          end
        end else begin
          lamp_d = lamp_q + LampW'(1);
        end
      end
      StRun: begin
        if (pend_now) begin
          state_d   = (code_now == 32'd0) ? StExitPass : StExitFail;
          pending_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    led_d = '0;
    case (state_q)
      StLamp:     led_d = '1;
      StRun:      led_d = run_led;
      StExitPass: led_d = '1;
      StExitFail: led_d = cnt_q[CNT_WIDTH-3] ? fail_pat : '0;
      default:    led_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ResetState;
      cnt_q       <= '0;
      lamp_q      <= '0;
      exit_q      <= '0;
      pending_q   <= 1'b0;
      exit_prev_q <= 1'b0;
      led_q       <= '0;
      hb_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lamp_q      <= lamp_d;
      exit_q      <= exit_d;
      pending_q   <= pending_d;
      exit_prev_q <= exit_valid_i;
      led_q       <= led_d;
      hb_q        <= cnt_q[CNT_WIDTH-1];
    end
  end

  assign led_o       = led_q;
  assign heartbeat_o = hb_q;

endmodule

// File: tb/tb_xilinx_status_led_ctrl.sv
// Scoreboard bench for xilinx_status_led_ctrl with a 6-bit prescaler and 5-cycle lamp test.
module tb_xilinx_status_led_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mode;
  logic [15:0] duty;
  logic        ev;
  logic [31:0] evv;
  logic [3:0]  led;
  logic        hb;

  typedef struct {
    int unsigned cyc;
    bit          chk_led;
    logic [3:0]  led;
    bit          chk_hb;
    logic        hb;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned c0 = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  xilinx_status_led_ctrl #(
    .NUM_LEDS   (4),
    .CNT_WIDTH  (6),
    .PWM_WIDTH  (4),
    .LAMP_CYCLES(5)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mode_i      (mode),
    .duty_i      (duty),
    .exit_valid_i(ev),
    .exit_value_i(evv),
    .led_o       (led),
    .heartbeat_o (hb)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Prescaler value seen just before posedge j, counted from the last reset release.
  function automatic int unsigned cnt_at(input int unsigned j);
    return (j - c0 - 1) % 64;
  endfunction

  function automatic logic blink8_at(input int unsigned j);
    int unsigned c;
    c = cnt_at(j);
    return ((c >> 3) & 1) == 1;
  endfunction

  // Ch0 PWM duty 4, ch1 PWM duty 0, ch2 PWM duty 15, ch3 BLINK.
  function automatic logic [3:0] exp_run(input int unsigned j);
    int unsigned c;
    logic [3:0] r;
    c = cnt_at(j);
    r[0] = (c % 16) < 4;
    r[1] = 1'b0;
    r[2] = (c % 16) < 15;
    r[3] = c >= 32;
    return r;
  endfunction

  task automatic push(input int unsigned c, input bit cl, input logic [3:0] l,
                      input bit ch, input logic h, input string n);
    exp_t e;
    e.cyc = c; e.chk_led = cl; e.led = l; e.chk_hb = ch; e.hb = h; e.name = n;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      if (mon_e.cyc != cyc) begin
        chk($sformatf("%s_missed@%0d", mon_e.name, mon_e.cyc), cyc, mon_e.cyc);
      end else begin
        if (mon_e.chk_led)
          chk($sformatf("%s_led@%0d", mon_e.name, cyc - c0), 32'(led), 32'(mon_e.led));
        if (mon_e.chk_hb)
          chk($sformatf("%s_hb@%0d", mon_e.name, cyc - c0), 32'(hb), 32'(mon_e.hb));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset(input string n);
    drain();
    tick();
    rst = 1'b1;
    #1;
    chk({n, "_rst_led"}, 32'(led), 32'h0);
    chk({n, "_rst_hb"}, 32'(hb), 32'h0);
    tick();
    rst = 1'b0;
    c0  = cyc;
  endtask

  task automatic push_lamp(input int unsigned n_after, input string n);
    for (int k = 1; k <= 5 + int'(n_after); k++)
      push(c0 + k, 1, (k <= 5) ? 4'hF : 4'h0, 0, 1'b0, n);
  endtask

  initial begin
    int unsigned c;
    rst = 1'b1; mode = '0; duty = '0; ev = 1'b0; evv = '0;
    tick(); tick();
    chk("init_led", 32'(led), 32'h0);
    chk("init_hb", 32'(hb), 32'h0);

    // Lamp test and heartbeat cadence.
    rst = 1'b0;
    c0  = cyc;
    for (int k = 1; k <= 70; k++)
      push(c0 + k, 1, (k <= 5) ? 4'hF : 4'h0,
           (k == 1 || k == 32 || k == 33 || k == 64 || k == 65), ((k - 1) % 64) >= 32, "lamp");
    drain();

    // Run modes.
    mode = 8'b10_11_11_11;
    duty = {4'd0, 4'd15, 4'd0, 4'd4};
    c = cyc;
    for (int k = 1; k <= 64; k++) push(c + k, 1, exp_run(c + k), 0, 1'b0, "run");
    drain();

    // Passing exit, then a later failing edge must be ignored.
    ev = 1'b1; evv = 32'h0;
    c = cyc;
    for (int k = 2; k <= 20; k++) push(c + k, 1, 4'hF, 0, 1'b0, "pass");
    drain();
    ev = 1'b0;
    tick();
    ev = 1'b1; evv = 32'h5;
    c = cyc;
    for (int k = 1; k <= 20; k++) push(c + k, 1, 4'hF, 0, 1'b0, "sticky");
    drain();
    ev = 1'b0;

    // Failing exit code 5.
    mode = '0;
    do_reset("r1");
    push_lamp(3, "lamp1");
    drain();
    ev = 1'b1; evv = 32'h5;
    c = cyc;
    for (int k = 2; k <= 33; k++)
      push(c + k, 1, blink8_at(c + k) ? 4'b0101 : 4'b0000, 0, 1'b0, "fail5");
    drain();
    ev = 1'b0;

    // Asynchronous reset while the fail pattern is lit.
    for (int i = 0; i < 64 && !blink8_at(cyc); i++) tick();
    chk("fail5_lit", 32'(led), 32'h5);
    rst = 1'b1;
    #1;
    chk("rst_async_led", 32'(led), 32'h0);
    tick();
    rst = 1'b0;
    c0  = cyc;
    push_lamp(4, "lamp2");
    drain();

    // Nonzero code with zero low bits blinks all LEDs.
    ev = 1'b1; evv = 32'h10;
    c = cyc;
    for (int k = 2; k <= 33; k++)
      push(c + k, 1, blink8_at(c + k) ? 4'hF : 4'h0, 0, 1'b0, "fail10");
    drain();
    ev = 1'b0;

    // Exit pulse mid-lamp is held until the lamp test finishes.
    do_reset("r3");
    for (int k = 1; k <= 30; k++) push(c0 + k, 1, 4'hF, 0, 1'b0, "lamp_exit");
    tick(); tick();
    ev = 1'b1; evv = 32'h0;
    tick();
    ev = 1'b0;
    drain();

    // Exit valid already high at reset release counts as an edge.
    ev = 1'b1; evv = 32'h5;
    do_reset("r4");
    for (int k = 1; k <= 30; k++)
      push(c0 + k, 1, (k <= 5) ? 4'hF : (blink8_at(c0 + k) ? 4'b0101 : 4'b0000), 0, 1'b0,
           "early_exit");
    drain();
    ev = 1'b0;

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
